sccb_write_arbiter: RTL and testbench

- Shares the single byte-level SCCB/I2C engine between two register-write requesters: the power-up init sequencer and a runtime control path (exposure/gain tweaks).
- Each granted request becomes one 3-byte SCCB write: device address, register address, data.
- Each byte is strobed into the engine, and the engine's busy flag paces the sequence.
- Sits between the requesters and the engine; the engine's strobe/data/lastTransfer inputs are driven only by this block.

---
 rtl/sccb_write_arbiter.sv | 141 ++++++++++++++
 tb/tb_sccb_write_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_write_arbiter.sv
// sccb_write_arbiter: round-robin arbiter that turns register-write requests into 3-byte SCCB writes
module sccb_write_arbiter #(
  parameter logic [7:0] DEV_ADDR   = 8'h42,
  parameter int         STROBE_GAP = 10,
  parameter int         TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] req0Addr,
  input  logic [7:0] req0Data,
  output logic       done0,
  input  logic       req1,
  input  logic [7:0] req1Addr,
  input  logic [7:0] req1Data,
  output logic       done1,
  input  logic       i2cBusy,
  output logic       i2cStrobe,
  output logic [7:0] dataToSend,
  output logic       lastTransfer,
  output logic       owner,
  output logic       arbBusy,
  output logic       error
);
  localparam int GW = $clog2(STROBE_GAP + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, SEND_DEV, GAP_DEV, WAIT_DEV, SEND_REG, GAP_REG, WAIT_REG,
    SEND_DAT, GAP_DAT, WAIT_DAT, FINISH
  } state_t;

  state_t         state_q, state_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [7:0]     addr_q, addr_d, dat_q, dat_d;
  logic           strobe_q, strobe_d;
  logic [7:0]     data_q, data_d;
  logic           last_q, last_d;
  logic           done0_q, done0_d, done1_q, done1_d;
  logic           error_q, error_d;
  logic           busy_q, busy_d;
  logic           owner_q, owner_d;
  logic           grant, winner, in_wait, tmo_hit, abort, send_next;

  // Tie goes to whoever did not win last time; a lone request always wins.
  assign grant   = (state_q == IDLE) && (req0 || req1);
  assign winner  = (req0 && req1) ? ~owner_q : req1;
  assign in_wait = state_q inside {WAIT_DEV, WAIT_REG, WAIT_DAT};
  assign tmo_hit = tmo_q == TW'(TIMEOUT - 1);
  assign abort   = in_wait && i2cBusy && tmo_hit;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: strobe, blind gap while the engine raises busy, then wait for busy to drop
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = grant ? SEND_DEV : IDLE;
      SEND_DEV: state_d = GAP_DEV;
      GAP_DEV:  state_d = (gap_q == '0) ? WAIT_DEV : GAP_DEV;
      WAIT_DEV: state_d = !i2cBusy ? SEND_REG : (tmo_hit ? FINISH : WAIT_DEV);
      SEND_REG: state_d = GAP_REG;
      GAP_REG:  state_d = (gap_q == '0) ? WAIT_REG : GAP_REG;
      WAIT_REG: state_d = !i2cBusy ? SEND_DAT : (tmo_hit ? FINISH : WAIT_REG);
      SEND_DAT: state_d = GAP_DAT;
      GAP_DAT:  state_d = (gap_q == '0) ? WAIT_DAT : GAP_DAT;
      WAIT_DAT: state_d = (!i2cBusy || tmo_hit) ? FINISH : WAIT_DAT;
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are computed from the state being entered
  always_comb begin
    send_next = state_d inside {SEND_DEV, SEND_REG, SEND_DAT};
    strobe_d  = send_next;
    data_d    = (state_d == SEND_DEV) ? DEV_ADDR :
                (state_d == SEND_REG) ? addr_q :
                (state_d == SEND_DAT) ? dat_q : data_q;
    last_d    = send_next ? (state_d == SEND_DAT) : last_q;
    busy_d    = state_d != IDLE;
    owner_d   = grant ? winner : owner_q;
    done0_d   = (state_d == FINISH) && !owner_d;
    done1_d   = (state_d == FINISH) && owner_d;
    error_d   = (state_d == FINISH) && abort;
  end

  // Counters and request latch: the gap counter is loaded as the strobe goes out, so the
  // gap lasts exactly STROBE_GAP cycles; the timeout counter only runs inside WAIT
  always_comb begin
    gap_d  = send_next ? GW'(STROBE_GAP) : ((gap_q != '0) ? gap_q - GW'(1) : gap_q);
    tmo_d  = (in_wait && i2cBusy) ? tmo_q + TW'(1) : '0;
    addr_d = grant ? (winner ? req1Addr : req0Addr) : addr_q;
    dat_d  = grant ? (winner ? req1Data : req0Data) : dat_q;
  end

  // Output, counter and latch registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_q    <= '0;
      tmo_q    <= '0;
      addr_q   <= '0;
      dat_q    <= '0;
      strobe_q <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
      owner_q  <= 1'b1;
    end else begin
      gap_q    <= gap_d;
      tmo_q    <= tmo_d;
      addr_q   <= addr_d;
      dat_q    <= dat_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
      last_q   <= last_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
      owner_q  <= owner_d;
    end
  end

  assign i2cStrobe    = strobe_q;
  assign dataToSend   = data_q;
  assign lastTransfer = last_q;
  assign done0        = done0_q;
  assign done1        = done1_q;
  assign error        = error_q;
  assign arbBusy      = busy_q;
  assign owner        = owner_q;
endmodule

// File: tb/tb_sccb_write_arbiter.sv
// tb_sccb_write_arbiter: table, corner-case and random checks of the SCCB write arbiter
module tb_sccb_write_arbiter;
  localparam int GAP = 10;
  localparam int TMO = 100;

  logic       clk = 1'b0, reset = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, i2cBusy = 1'b0;
  logic [7:0] req0Addr = '0, req0Data = '0, req1Addr = '0, req1Data = '0;
  logic       done0, done1, i2cStrobe, lastTransfer, owner, arbBusy, error;
  logic [7:0] dataToSend;

  sccb_write_arbiter #(.DEV_ADDR(8'h42), .STROBE_GAP(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req0Addr(req0Addr), .req0Data(req0Data), .done0(done0),
    .req1(req1), .req1Addr(req1Addr), .req1Data(req1Data), .done1(done1),
    .i2cBusy(i2cBusy), .i2cStrobe(i2cStrobe), .dataToSend(dataToSend),
    .lastTransfer(lastTransfer), .owner(owner), .arbBusy(arbBusy), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct { int who; int err; int len; int n; logic [26:0] stb; } rec_t;
  typedef struct {
    bit r0, r1; logic [7:0] a0, d0, a1, d1; int h0, h1, h2;
    int first; int err; int len; int n;
  } vec_t;

  rec_t       recs[$];
  vec_t       tv[8];
  int         errs = 0, checks = 0, stray = 0;
  int         run_len = 0, sn = 0;
  logic [26:0] cur_stb = '0;
  int         hold[3];
  int         left = 0, idx = 0;
  int         want0 = 0, want1 = 0, off0 = 0, off1 = 0;
  int         m_owner;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: sample DUT at the falling edge, log transactions, model the engine, drive requesters
  task automatic tick();
    rec_t r;
    @(negedge clk);
    if (!reset) begin
      run_len = 0; sn = 0; cur_stb = '0; left = 0; idx = 0; i2cBusy = 1'b0;
      return;
    end
    if (arbBusy) run_len++;
    if (i2cStrobe) begin
      if (!arbBusy) stray++;
      if (sn < 3) cur_stb[sn*9 +: 9] = {lastTransfer, dataToSend};
      sn++;
    end
    if (error && !(done0 || done1)) stray++;
    if (done0 || done1) begin
      if ((done0 && done1) || !arbBusy) stray++;
      r.who = done1 ? 1 : 0; r.err = error ? 1 : 0; r.len = run_len; r.n = sn; r.stb = cur_stb;
      recs.push_back(r);
      run_len = 0; sn = 0; cur_stb = '0;
    end
    if (i2cStrobe) begin
      left = (idx < 3) ? hold[idx] : 0;
      idx++;
    end else if (left > 0) left--;
    if (done0 || done1) begin left = 0; idx = 0; end
    i2cBusy = left > 0;
    if (done0) begin req0 = 1'b0; if (want0 > 0) want0--; off0 = 1; end
    else if (off0 > 0) off0--;
    else if (!req0 && want0 > 0) req0 = 1'b1;
    if (done1) begin req1 = 1'b0; if (want1 > 0) want1--; off1 = 1; end
    else if (off1 > 0) off1--;
    else if (!req1 && want1 > 0) req1 = 1'b1;
  endtask

  task automatic wait_recs(int n, int budget, string tag);
    int k = 0;
    while (recs.size() < n && k < budget) begin tick(); k++; end
    chk({tag, "_count"}, recs.size(), n);
  endtask

  task automatic check_rec(string tag, int who, int err, int len, int n, logic [7:0] a, logic [7:0] d);
    rec_t r;
    logic [26:0] e;
    if (recs.size() == 0) return;
    r = recs.pop_front();
    e = {1'b1, d, 1'b0, a, 1'b0, 8'h42};
    chk({tag, "_who"}, r.who, who);
    chk({tag, "_err"}, r.err, err);
    chk({tag, "_len"}, r.len, len);
    chk({tag, "_nstrobe"}, r.n, n);
    for (int i = 0; i < 3; i++)
      if (i < n && i < r.n) chk($sformatf("%s_byte%0d", tag, i), r.stb[i*9 +: 9], e[i*9 +: 9]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  // Busy is seen for h cycles starting at the strobe; the first WAIT look is GAP+1 cycles after
  // the strobe; a byte aborts once busy has been high for TMO WAIT cycles.
  function automatic void model(input int h0, input int h1, input int h2,
                                output int len, output int n, output int err);
    int h[3];
    h = '{h0, h1, h2};
    len = 1; n = 0; err = 0;
    for (int b = 0; b < 3 && err == 0; b++) begin
      n++;
      if (h[b] >= GAP + 1 + TMO) begin err = 1; len += GAP + 1 + TMO; end
      else len += (h[b] + 1 > GAP + 2) ? h[b] + 1 : GAP + 2;
    end
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nexp, len, n, err, first, mode, w;
    logic [7:0] ra0, rd0, ra1, rd1;
    hold = '{0, 0, 0};
    tv[0] = '{1, 0, 8'h12, 8'h80, 8'h00, 8'h00,  20,  20,  20, 0, 0,  64, 3};
    tv[1] = '{0, 1, 8'h00, 8'h00, 8'h34, 8'h56,   0,   0,   0, 1, 0,  37, 3};
    tv[2] = '{1, 1, 8'hA1, 8'hB1, 8'hA2, 8'hB2,   5,   5,   5, 0, 0,  37, 3};
    tv[3] = '{1, 1, 8'h0F, 8'hF0, 8'h3C, 8'hC3,   0,  20,   3, 0, 0,  46, 3};
    tv[4] = '{1, 0, 8'h77, 8'h88, 8'h00, 8'h00,   0,   0, 110, 0, 0, 136, 3};
    tv[5] = '{0, 1, 8'h00, 8'h00, 8'h9A, 8'hBC,   0, 111,   0, 1, 1, 124, 2};
    tv[6] = '{1, 0, 8'h55, 8'hAA, 8'h00, 8'h00, 200,   0,   0, 0, 1, 112, 1};
    tv[7] = '{1, 1, 8'h01, 8'h02, 8'hFE, 8'hFD,  11,  12,  13, 1, 0,  40, 3};

    repeat (3) tick();
    chk("rst_strobe", i2cStrobe, 0);
    chk("rst_data", dataToSend, 0);
    chk("rst_last", lastTransfer, 0);
    chk("rst_done0", done0, 0);
    chk("rst_done1", done1, 0);
    chk("rst_error", error, 0);
    chk("rst_busy", arbBusy, 0);
    chk("rst_owner", owner, 1);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      req0Addr = tv[i].a0; req0Data = tv[i].d0; req1Addr = tv[i].a1; req1Data = tv[i].d1;
      hold = '{tv[i].h0, tv[i].h1, tv[i].h2};
      want0 = tv[i].r0; want1 = tv[i].r1;
      nexp = tv[i].r0 + tv[i].r1;
      wait_recs(nexp, 2000, $sformatf("vec%0d", i));
      check_rec($sformatf("vec%0d_a", i), tv[i].first, tv[i].err, tv[i].len, tv[i].n,
                tv[i].first ? tv[i].a1 : tv[i].a0, tv[i].first ? tv[i].d1 : tv[i].d0);
      if (nexp == 2)
        check_rec($sformatf("vec%0d_b", i), 1 - tv[i].first, tv[i].err, tv[i].len, tv[i].n,
                  tv[i].first ? tv[i].a0 : tv[i].a1, tv[i].first ? tv[i].d0 : tv[i].d1);
      repeat (2) tick();
      chk($sformatf("vec%0d_idle", i), arbBusy, 0);
    end

    hold = '{0, 0, 0};
    req0Addr = 8'h5A; req0Data = 8'hA5; want0 = 1;
    for (int k = 0; k < 200 && sn < 2; k++) tick();
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("midrst_strobe", i2cStrobe, 0);
    chk("midrst_data", dataToSend, 0);
    chk("midrst_last", lastTransfer, 0);
    chk("midrst_done", {done1, done0}, 0);
    chk("midrst_error", error, 0);
    chk("midrst_busy", arbBusy, 0);
    chk("midrst_owner", owner, 1);
    repeat (3) tick();
    chk("midrst_nodone", recs.size(), 0);
    reset = 1'b1;
    wait_recs(1, 200, "midrst_restart");
    check_rec("midrst_restart", 0, 0, 37, 3, 8'h5A, 8'hA5);

    hold = '{30, 0, 0};
    req1Addr = 8'h11; req1Data = 8'h22; want1 = 1;
    for (int k = 0; k < 200 && sn < 1; k++) tick();
    repeat (15) tick();
    req1 = 1'b0; want1 = 0;
    wait_recs(1, 200, "drop");
    check_rec("drop", 1, 0, 56, 3, 8'h11, 8'h22);
    repeat (20) tick();
    chk("drop_norepeat", recs.size(), 0);
    chk("drop_idle", arbBusy, 0);

    do_reset();
    hold = '{0, 0, 0};
    req0Addr = 8'h01; req0Data = 8'h02; req1Addr = 8'h03; req1Data = 8'h04;
    want0 = 2; want1 = 2;
    wait_recs(4, 1000, "fair");
    for (int k = 0; k < 4; k++)
      check_rec($sformatf("fair%0d", k), k % 2, 0, 37, 3,
                (k % 2) ? 8'h03 : 8'h01, (k % 2) ? 8'h04 : 8'h02);
    repeat (3) tick();

    do_reset();
    m_owner = 1;
    for (int it = 0; it < 25; it++) begin
      mode = $urandom_range(1, 3);
      ra0 = 8'($urandom); rd0 = 8'($urandom); ra1 = 8'($urandom); rd1 = 8'($urandom);
      req0Addr = ra0; req0Data = rd0; req1Addr = ra1; req1Data = rd1;
      for (int b = 0; b < 3; b++)
        hold[b] = ($urandom_range(0, 9) == 0) ? 150 : $urandom_range(0, 24);
      model(hold[0], hold[1], hold[2], len, n, err);
      first = (mode == 3) ? 1 - m_owner : (mode == 2 ? 1 : 0);
      nexp = (mode == 3) ? 2 : 1;
      want0 = mode & 1; want1 = mode >> 1;
      wait_recs(nexp, 3000, $sformatf("rnd%0d", it));
      check_rec($sformatf("rnd%0d_a", it), first, err, len, n,
                first ? ra1 : ra0, first ? rd1 : rd0);
      w = first;
      if (nexp == 2) begin
        check_rec($sformatf("rnd%0d_b", it), 1 - first, err, len, n,
                  first ? ra0 : ra1, first ? rd0 : rd1);
        w = 1 - first;
      end
      m_owner = w;
      repeat ($urandom_range(1, 4)) tick();
    end

    chk("no_stray_strobe_done_error", stray, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
